// File: rtl/math_question_gen.sv
// math_question_gen: wake-up arithmetic question generator and answer checker.
// Optional SUBTRACT_EN macro alternates addition and subtraction questions.
module math_question_gen #(
  parameter int         OPERAND_MAX = 49,
  parameter int         MAX_TRIES   = 3,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       alarm_on,
  input  logic [6:0] answer_in,
  input  logic       submit,
  output logic       question,
  output logic [6:0] question_a,
  output logic [6:0] question_b,
  output logic [6:0] question_c,
  output logic       op_sub,
  output logic       alarm_dismiss,
  output logic       wrong,
  output logic [2:0] tries
);
  typedef enum logic [2:0] {IDLE, GEN_A, GEN_B, ASK, CHECK, DONE} state_t;
  localparam logic [5:0] OP_MAX = 6'(OPERAND_MAX);
  localparam logic [2:0] MAX_T  = 3'(MAX_TRIES);
  state_t     state;
  logic [7:0] lfsr;
  logic [6:0] ans, expect_v, cand;
  logic       ok;
  assign cand = {1'b0, lfsr[5:0]};
  assign ok   = lfsr[5:0] <= OP_MAX;
`ifdef SUBTRACT_EN
  logic toggle;
  assign expect_v = op_sub ? question_a - question_b : question_a + question_b;
`else
  assign op_sub   = 1'b0;
  assign expect_v = question_a + question_b;
`endif
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state         <= IDLE;
      lfsr          <= LFSR_SEED;
      question      <= 1'b0;
      question_a    <= '0;
      question_b    <= '0;
      question_c    <= '0;
      alarm_dismiss <= 1'b0;
      wrong         <= 1'b0;
      tries         <= '0;
      ans           <= '0;
`ifdef SUBTRACT_EN
      toggle        <= 1'b1;
      op_sub        <= 1'b0;
`endif
    end else begin
      lfsr          <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      alarm_dismiss <= 1'b0;
      wrong         <= 1'b0;
      if (!alarm_on) begin
        state      <= IDLE;
        question   <= 1'b0;
        question_a <= '0;
        question_b <= '0;
        question_c <= '0;
        tries      <= '0;
`ifdef SUBTRACT_EN
        op_sub     <= 1'b0;
`endif
      end else
        case (state)
          IDLE: begin
            state      <= GEN_A;
            question_a <= '0;
            question_b <= '0;
`ifdef SUBTRACT_EN
            toggle     <= ~toggle;
            op_sub     <= 1'b0;
`endif
          end
          GEN_A: if (ok) begin
            question_a <= cand;
            state      <= GEN_B;
          end
          GEN_B: if (ok) begin
`ifdef SUBTRACT_EN
            // larger operand always lands in a so a-b never goes negative
            if (question_a < cand) begin
              question_a <= cand;
              question_b <= question_a;
            end else
              question_b <= cand;
            op_sub <= toggle;
`else
            question_b <= cand;
`endif
            state    <= ASK;
            question <= 1'b1;
          end
          ASK: begin
            question_c <= answer_in;
            if (submit) begin
              ans   <= answer_in;
              state <= CHECK;
            end
          end
          CHECK: if (ans == expect_v) begin
            state         <= DONE;
            alarm_dismiss <= 1'b1;
            question      <= 1'b0;
            question_c    <= '0;
            tries         <= '0;
          end else begin
            wrong <= 1'b1;
            if (tries + 3'd1 == MAX_T) begin
              tries      <= '0;
              state      <= GEN_A;
              question   <= 1'b0;
              question_c <= '0;
`ifdef SUBTRACT_EN
              toggle     <= ~toggle;
`endif
            end else begin
              tries <= tries + 3'd1;
              state <= ASK;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_math_question_gen.sv
// tb_math_question_gen: randomized checks of math_question_gen against a question-level model.
module tb_math_question_gen;
  logic       clock = 0, reset = 0, alarm_on = 0, submit = 0;
  logic [6:0] answer_in = 0;
  logic       question, op_sub, alarm_dismiss, wrong;
  logic [6:0] question_a, question_b, question_c;
  logic [2:0] tries;
  int n_chk = 0, n_fail = 0;
  int ea, eb, es, tog, etries;
  logic [7:0] m;

  math_question_gen dut (
    .clock(clock), .reset(reset), .alarm_on(alarm_on), .answer_in(answer_in),
    .submit(submit), .question(question), .question_a(question_a),
    .question_b(question_b), .question_c(question_c), .op_sub(op_sub),
    .alarm_dismiss(alarm_dismiss), .wrong(wrong), .tries(tries)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(posedge clock or negedge reset)
    if (!reset) m <= 8'hA5;
    else m <= step(m);

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // v is the LFSR value the first operand search starts from
  function automatic void predict(input logic [7:0] v);
    int t;
    while (v[5:0] > 49) v = step(v);
    ea = v[5:0];
    v = step(v);
    while (v[5:0] > 49) v = step(v);
    eb = v[5:0];
`ifdef SUBTRACT_EN
    tog = 1 - tog;
    es = tog;
    if (ea < eb) begin t = ea; ea = eb; eb = t; end
`else
    es = 0;
`endif
  endfunction

  function automatic int ev();
    return es ? ea - eb : ea + eb;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_q"}, question, 0);
    check({tag, "_a"}, question_a, 0);
    check({tag, "_b"}, question_b, 0);
    check({tag, "_c"}, question_c, 0);
    check({tag, "_dis"}, alarm_dismiss, 0);
    check({tag, "_wr"}, wrong, 0);
    check({tag, "_tries"}, tries, 0);
    check({tag, "_sub"}, op_sub, 0);
  endtask

  task automatic wait_q();
    int n = 0;
    while (!question && n < 200) begin @(negedge clock); n++; end
    check("q_timeout", question, 1);
    check("op_a", question_a, ea);
    check("op_b", question_b, eb);
    check("op_sub", op_sub, es);
    check("a_max", question_a <= 49, 1);
    check("b_max", question_b <= 49, 1);
    check("tries0", tries, etries);
  endtask

  task automatic start_q();
    @(negedge clock);
    alarm_on = 1;
    etries = 0;
    predict(step(m));
    @(negedge clock);
    wait_q();
  endtask

  task automatic do_submit(input int x, output bit done);
    logic [7:0] l;
    done = 0;
    @(negedge clock);
    answer_in = 7'(x);
    submit = 1;
    l = m;
    @(negedge clock);
    submit = 0;
    check("echo", question_c, x);
    check("early", alarm_dismiss | wrong, 0);
    @(negedge clock);
    if (x == ev()) begin
      done = 1;
      check("dismiss", alarm_dismiss, 1);
      check("dis_wr", wrong, 0);
      check("dis_q", question, 0);
      check("dis_c", question_c, 0);
      check("dis_tries", tries, 0);
      alarm_on = 0;
      @(negedge clock);
      check("dis_len", alarm_dismiss, 0);
      check("idle_a", question_a, 0);
      check("idle_b", question_b, 0);
    end else begin
      check("wrong", wrong, 1);
      check("wr_dis", alarm_dismiss, 0);
      etries++;
      if (etries == 3) begin
        etries = 0;
        check("regen_tries", tries, 0);
        check("regen_q", question, 0);
        predict(step(step(l)));
        @(negedge clock);
        check("wr_len", wrong, 0);
        wait_q();
      end else begin
        check("tries", tries, etries);
        check("wr_q", question, 1);
        check("hold_a", question_a, ea);
        check("hold_b", question_b, eb);
        @(negedge clock);
        check("wr_len", wrong, 0);
      end
    end
  endtask

  task automatic idle_echo(input int n);
    logic [6:0] r;
    repeat (n) begin
      r = 7'($urandom_range(0, 127));
      answer_in = r;
      @(negedge clock);
      check("echo_idle", question_c, r);
      check("hold_a_idle", question_a, ea);
      check("hold_b_idle", question_b, eb);
      check("no_pulse", alarm_dismiss | wrong, 0);
    end
  endtask

  initial begin
    bit done;
    int x;
    tog = 1;
    etries = 0;
    repeat (3) @(negedge clock);
    check_zero("rst");
    reset = 1;
    repeat (3) @(negedge clock);
    check_zero("post_rst");
    // reset asserted mid-question
    start_q();
    idle_echo(2);
    @(negedge clock);
    reset = 0;
    #1 check_zero("async_rst");
    alarm_on = 0;
    tog = 1;
    @(negedge clock);
    reset = 1;
    repeat (2) @(negedge clock);
    check_zero("rst_idle");
    // out-of-range answer and exhausting retries
    start_q();
    do_submit(127, done);
    do_submit((ev() + 1) % 128, done);
    do_submit((ev() + 2) % 128, done);
    do_submit(ev(), done);
    check("dismiss_after_regen", done, 1);
    for (int k = 0; k < 12; k++) begin
      start_q();
      done = 0;
      for (int s = 0; s < 6 && !done; s++) begin
        idle_echo($urandom_range(0, 3));
        if (s == 5 || $urandom_range(0, 2) == 0) x = ev();
        else begin
          x = $urandom_range(0, 127);
          if (x == ev()) x = (x + 1) % 128;
        end
        do_submit(x, done);
      end
      check("round_done", done, 1);
    end
    // alarm drops with a correct submit in the same cycle
    start_q();
    @(negedge clock);
    answer_in = 7'(ev());
    submit = 1;
    alarm_on = 0;
    @(negedge clock);
    submit = 0;
    check_zero("alarm_off");
    repeat (2) begin
      @(negedge clock);
      check("alarm_off_dis", alarm_dismiss, 0);
      check("alarm_off_q", question, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
